// File: rtl/sort_pkg.sv
// Shared constants and types for the round-robin sort scheduler.
// The engine geometry (W, N, SORT_LAT) is fixed here so every user agrees on it.
package sort_pkg;
    localparam int W        = 16;
    localparam int N        = 5;
    localparam int SORT_LAT = 2;
    localparam int CNTW     = $clog2(N);
    localparam int WCW      = $clog2(SORT_LAT + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GATHER = 2'd1,
        ST_WAIT   = 2'd2,
        ST_EMIT   = 2'd3
    } state_e;

    // Word k of a frame sits at [k*W +: W]; word 0 feeds engine input 1.
    typedef logic [N-1:0][W-1:0] frame_t;

    function automatic int wrap_inc(input int v, input int m);
        return (v + 1 >= m) ? 0 : v + 1;
    endfunction
endpackage

// File: rtl/sort_sched_rr_arbiter.sv
// Combinational round-robin pick: the first asserted request at or above ptr, with wrap.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic            any,
    output logic [IDW-1:0]  gnt
);
    // Scan from the farthest offset down so the nearest requester is written last and wins.
    always_comb begin
        any = 1'b0;
        gnt = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % NREQ]) begin
                any = 1'b1;
                gnt = IDW'((int'(ptr) + i) % NREQ);
            end
        end
    end
endmodule

// File: rtl/sort_sched.sv
// Sequences one shared 5-input descending sort engine among NREQ requesters:
// gather a frame, hold it on the engine until the result settles, then stream it out.
module sort_sched
    import sort_pkg::*;
#(
    parameter int NREQ = 2,
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic [N*W-1:0]    eng_data_o,
    input  logic [N*W-1:0]    eng_data_i,
    output logic              out_valid,
    output logic [W-1:0]      out_data,
    output logic [IDW-1:0]    out_id,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy
);
    state_e          state;
    logic [IDW-1:0]  gnt;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  arb_gnt;
    logic            arb_any;
    logic [CNTW-1:0] cnt;
    logic [CNTW-1:0] k;
    logic [WCW-1:0]  wcnt;
    frame_t          frame;
    frame_t          result;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req (req_valid),
        .ptr (rr_ptr),
        .any (arb_any),
        .gnt (arb_gnt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            gnt    <= '0;
            rr_ptr <= '0;
            cnt    <= '0;
            k      <= '0;
            wcnt   <= '0;
            frame  <= '0;
            result <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        gnt   <= arb_gnt;
                        cnt   <= '0;
                        state <= ST_GATHER;
                    end
                end
                ST_GATHER: begin
                    if (req_valid[gnt]) begin
                        frame[cnt] <= req_data[int'(gnt)*W +: W];
                        if (cnt == CNTW'(N - 1)) begin
                            wcnt  <= '0;
                            state <= ST_WAIT;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                // Frame is already on eng_data_o; SORT_LAT+1 cycles lets both engine registers fill.
                ST_WAIT: begin
                    if (wcnt == WCW'(SORT_LAT)) begin
                        result <= eng_data_i;
                        k      <= '0;
                        state  <= ST_EMIT;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        if (k == CNTW'(N - 1)) begin
                            rr_ptr <= IDW'(wrap_inc(int'(gnt), NREQ));
                            state  <= ST_IDLE;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == ST_GATHER) req_ready[gnt] = 1'b1;
    end

    assign eng_data_o = frame;
    assign busy       = (state != ST_IDLE);
    assign out_valid  = (state == ST_EMIT);
    assign out_data   = (state == ST_EMIT) ? result[k] : '0;
    assign out_id     = (state == ST_EMIT) ? gnt : '0;
    assign out_last   = (state == ST_EMIT) && (k == CNTW'(N - 1));
endmodule

// File: tb/tb_sort_sched.sv
// Directed bench for sort_sched with a behavioural two-register sort engine
// and a scoreboard of expected {last, id, word} entries.
module tb_sort_sched;
    import sort_pkg::*;

    localparam int NREQ = 2;
    localparam int IDW  = 1;
    localparam int EW   = W + IDW + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic [N*W-1:0]    eng_data_o;
    logic [N*W-1:0]    eng_data_i;
    logic              out_valid;
    logic [W-1:0]      out_data;
    logic [IDW-1:0]    out_id;
    logic              out_last;
    logic              out_ready;
    logic              busy;

    logic              drv_valid [NREQ];
    logic [W-1:0]      drv_data  [NREQ];
    logic [EW-1:0]     exp_q[$];
    int                n_cmp  = 0;
    int                n_fail = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    sort_sched #(.NREQ(NREQ)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .eng_data_o (eng_data_o),
        .eng_data_i (eng_data_i),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_id     (out_id),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    always_comb begin
        for (int r = 0; r < NREQ; r++) begin
            req_valid[r]          = drv_valid[r];
            req_data[r*W +: W]    = drv_data[r];
        end
    end

    // ---------------- engine model ----------------
    function automatic frame_t sort_desc(input frame_t f);
        frame_t s;
        logic [W-1:0] t;
        s = f;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N - 1 - i; j++)
                if (s[j] < s[j+1]) begin
                    t = s[j]; s[j] = s[j+1]; s[j+1] = t;
                end
        return s;
    endfunction

    frame_t eng_s1 = '0;
    frame_t eng_s2 = '0;
    always @(posedge clk) begin
        eng_s1 <= eng_data_o;
        eng_s2 <= sort_desc(eng_s1);
    end
    assign eng_data_i = eng_s2;

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic frame_t mk(input logic [W-1:0] a, b, c, d, e);
        frame_t f;
        f[0] = a; f[1] = b; f[2] = c; f[3] = d; f[4] = e;
        return f;
    endfunction

    task automatic push_exp(input int id, input frame_t s);
        for (int i = 0; i < N; i++)
            exp_q.push_back({(i == N - 1), IDW'(id), s[i]});
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ready"}, 32'(req_ready), 0);
        check({tag, "_valid"}, 32'(out_valid), 0);
        check({tag, "_data"},  32'(out_data), 0);
        check({tag, "_id"},    32'(out_id), 0);
        check({tag, "_last"},  32'(out_last), 0);
        check({tag, "_busy"},  32'(busy), 0);
        check({tag, "_eng"},   32'(eng_data_o == '0), 1);
    endtask

    task automatic do_reset();
        for (int r = 0; r < NREQ; r++) drv_valid[r] = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        check_reset("rst");
        rst_n = 1'b1;
    endtask

    // ---------------- driver ----------------
    task automatic send_word(input int r, input logic [W-1:0] d);
        int n;
        logic ok;
        drv_valid[r] = 1'b1;
        drv_data[r]  = d;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 300) begin
            @(negedge clk);
            if (req_ready[r]) ok = 1'b1;
            else n++;
        end
        check("req_handshake", 32'(ok), 1);
        @(posedge clk);
        #1;
        drv_valid[r] = 1'b0;
    endtask

    task automatic send_frame(input int r, input frame_t f);
        for (int i = 0; i < N; i++) send_word(r, f[i]);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 400) begin
            step();
            n++;
        end
        check("drain", 32'(exp_q.size() == 0 && !busy), 1);
    endtask

    // ---------------- scoreboard / monitor ----------------
    logic          hold_prev = 1'b0;
    logic [W-1:0]  prev_data;
    logic [IDW-1:0] prev_id;
    logic          prev_last;

    always @(negedge clk) begin
        if (rst_n) begin
            check("rdy_onehot", 32'($countones(req_ready) <= 1), 1);
            if (hold_prev) begin
                check("hold_valid", 32'(out_valid), 1);
                check("hold_data",  32'(out_data), 32'(prev_data));
                check("hold_id",    32'(out_id), 32'(prev_id));
                check("hold_last",  32'(out_last), 32'(prev_last));
            end
            if (out_valid && out_ready) begin
                check("spurious_out", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    logic [EW-1:0] e;
                    e = exp_q.pop_front();
                    check("out_data", 32'(out_data), 32'(e[W-1:0]));
                    check("out_id",   32'(out_id),   32'(e[W+IDW-1:W]));
                    check("out_last", 32'(out_last), 32'(e[EW-1]));
                end
            end
            hold_prev = out_valid && !out_ready;
            prev_data = out_data;
            prev_id   = out_id;
            prev_last = out_last;
        end else begin
            hold_prev = 1'b0;
        end
    end

    // ---------------- directed sequence ----------------
    frame_t f1;
    frame_t fr0 [4];
    frame_t fr1 [4];

    initial begin
        for (int r = 0; r < NREQ; r++) begin
            drv_valid[r] = 1'b0;
            drv_data[r]  = '0;
        end
        out_ready = 1'b1;

        // Test 1: single frame with cycle-exact timing checks.
        rst_n = 1'b0;
        repeat (3) step();
        check_reset("t1_rst");
        rst_n = 1'b1;
        f1 = mk(16'd3, 16'd9, 16'd1, 16'd7, 16'd5);
        push_exp(0, mk(16'd9, 16'd7, 16'd5, 16'd3, 16'd1));
        drv_valid[0] = 1'b1;
        drv_data[0]  = f1[0];
        check("t1_c0_ready", 32'(req_ready), 0);
        step();
        for (int i = 0; i < N; i++) begin
            check("t1_gather_ready", 32'(req_ready), 32'b01);
            step();
            if (i < N - 1) drv_data[0] = f1[i+1];
            else drv_valid[0] = 1'b0;
        end
        for (int c = 6; c < 9; c++) begin
            check("t1_wait_valid", 32'(out_valid), 0);
            check("t1_wait_busy", 32'(busy), 1);
            step();
        end
        check("t1_c9_valid", 32'(out_valid), 1);
        repeat (5) step();
        check("t1_c14_busy", 32'(busy), 0);
        check("t1_c14_valid", 32'(out_valid), 0);
        drain();

        // Test 2: two requesters contending, ownership must alternate.
        do_reset();
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < N; i++) begin
                fr0[f][i] = W'($urandom_range(0, 16'hFFFF));
                fr1[f][i] = W'($urandom_range(0, 16'hFFFF));
            end
            push_exp(0, sort_desc(fr0[f]));
            push_exp(1, sort_desc(fr1[f]));
        end
        fork
            begin
                for (int f = 0; f < 4; f++) send_frame(0, fr0[f]);
            end
            begin
                for (int f = 0; f < 4; f++) send_frame(1, fr1[f]);
            end
        join
        drain();

        // Test 3: backpressure while the second word is presented.
        push_exp(0, mk(16'd9, 16'd7, 16'd5, 16'd3, 16'd1));
        send_frame(0, mk(16'd3, 16'd9, 16'd1, 16'd7, 16'd5));
        begin
            int n;
            n = 0;
            while (!out_valid && n < 20) begin
                step();
                n++;
            end
        end
        check("t3_first_valid", 32'(out_valid), 1);
        check("t3_first_data", 32'(out_data), 9);
        step();
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check("t3_bp_valid", 32'(out_valid), 1);
            check("t3_bp_data", 32'(out_data), 7);
            step();
        end
        out_ready = 1'b1;
        drain();

        // Test 4: requester bubble; another requester must not steal the grant.
        push_exp(0, mk(16'd8, 16'd6, 16'd4, 16'd2, 16'd2));
        send_word(0, 16'd4);
        send_word(0, 16'd2);
        drv_valid[1] = 1'b1;
        drv_data[1]  = 16'hAAAA;
        for (int c = 0; c < 3; c++) begin
            check("t4_bubble_ready", 32'(req_ready), 32'b01);
            check("t4_bubble_busy", 32'(busy), 1);
            step();
        end
        drv_valid[1] = 1'b0;
        send_word(0, 16'd8);
        send_word(0, 16'd6);
        send_word(0, 16'd2);
        drain();

        // Test 5: extremes and duplicates from requester 1.
        push_exp(1, mk(16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 16'd0));
        send_frame(1, mk(16'hFFFF, 16'd0, 16'hFFFF, 16'd1, 16'd0));
        drain();

        // Test 6: reset during WAIT discards the frame entirely.
        send_frame(0, mk(16'd11, 16'd22, 16'd33, 16'd44, 16'd55));
        check("t6_in_wait", 32'(busy && !out_valid && req_ready == '0), 1);
        rst_n = 1'b0;
        step();
        check_reset("t6_rst");
        rst_n = 1'b1;
        step();
        check("t6_idle_valid", 32'(out_valid), 0);
        push_exp(0, mk(16'd10, 16'd8, 16'd6, 16'd4, 16'd2));
        send_frame(0, mk(16'd2, 16'd4, 16'd6, 16'd8, 16'd10));
        drain();

        check("final_queue_empty", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "global timeout");
    end
endmodule
